// File: rtl/beam_threshold_loader.sv
// Purpose: shadow per-beam trigger thresholds and serialise dirty ones onto the beamformer thresh bus, then pulse update.
// Latency: commit at cycle T -> beam k on thresh_ce_o at T+2+k, update_o at T+NBEAMS+2, done_o at T+NBEAMS+3; readback 1 cycle.
// Backpressure: none; writes are accepted in every state, and commits arriving while busy merge into one pending flag.
module beam_threshold_loader #(
  parameter int                      NBEAMS         = 46,
  parameter int                      THRESH_BITS    = 18,
  parameter logic [THRESH_BITS-1:0]  DEFAULT_THRESH = 18'h3FFFF,
  parameter bit                      AUTO_LOAD      = 1'b1,
  localparam int                     AW             = $clog2(NBEAMS)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   wr_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [THRESH_BITS-1:0] wr_data_i,
  input  logic [AW-1:0]          rd_addr_i,
  output logic [THRESH_BITS-1:0] rd_data_o,
  input  logic                   commit_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [NBEAMS-1:0]      dirty_o,
  output logic [THRESH_BITS-1:0] thresh_o,
  output logic [NBEAMS-1:0]      thresh_ce_o,
  output logic                   update_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NBEAMS - 1);

  state_t                   state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic                     pending_q, pending_d;
  logic [THRESH_BITS-1:0]   shadow_q [NBEAMS];
  logic [NBEAMS-1:0]        dirty_q, dirty_d;
  logic [THRESH_BITS-1:0]   thresh_q, thresh_d;
  logic [NBEAMS-1:0]        ce_q, ce_d;
  logic                     update_q, update_d;
  logic                     done_q, done_d;
  logic [THRESH_BITS-1:0]   rd_data_q, rd_data_d;
  logic                     wr_ok;

  // Out-of-range beam indices are dropped so they can never alias onto a real beam.
  assign wr_ok = wr_i && (wr_addr_i <= LAST_IDX);

  // Next state and registered bus outputs; the scan reads shadow/dirty before this cycle's write lands.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    thresh_d  = thresh_q;
    ce_d      = '0;
    update_d  = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_i || pending_q) begin
          state_d   = LOAD;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      LOAD: begin
        if (commit_i) pending_d = 1'b1;
        if (dirty_q[idx_q]) begin
          thresh_d    = shadow_q[idx_q];
          ce_d[idx_q] = 1'b1;
        end
        if (idx_q == LAST_IDX) state_d = UPDATE;
        else                   idx_d   = idx_q + 1'b1;
      end
      UPDATE: begin
        if (commit_i) pending_d = 1'b1;
        update_d = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        if (commit_i) pending_d = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Dirty mask: the scanned beam is cleared, but a write on the same edge re-marks it.
  always_comb begin
    dirty_d = dirty_q;
    if (state_q == LOAD) dirty_d[idx_q] = 1'b0;
    if (wr_ok)           dirty_d[wr_addr_i] = 1'b1;
  end

  // Readback returns the pre-write shadow value; unmapped addresses read as zero.
  always_comb begin
    rd_data_d = '0;
    if (rd_addr_i <= LAST_IDX) rd_data_d = shadow_q[rd_addr_i];
  end

  // Control state and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= AUTO_LOAD;
      dirty_q   <= '1;
      thresh_q  <= '0;
      ce_q      <= '0;
      update_q  <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      dirty_q   <= dirty_d;
      thresh_q  <= thresh_d;
      ce_q      <= ce_d;
      update_q  <= update_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Shadow register file.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NBEAMS; i++) shadow_q[i] <= DEFAULT_THRESH;
    end else if (wr_ok) begin
      shadow_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign busy_o      = (state_q == LOAD) || (state_q == UPDATE);
  assign done_o      = done_q;
  assign dirty_o     = dirty_q;
  assign thresh_o    = thresh_q;
  assign thresh_ce_o = ce_q;
  assign update_o    = update_q;
  assign rd_data_o   = rd_data_q;

endmodule
